// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the instruction fetch sequencer.
// Covers the 256 x 9-bit instruction ROM configuration.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int         DEF_ADDR_W     = 8;
  localparam int         DEF_INSTR_W    = 9;
  localparam int         DEF_CNT_W      = 16;
  localparam logic [7:0] DEF_START_ADDR = 8'h00;

endpackage

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, drives the ROM address, registers the fetched instruction.
// Optional retired-instruction counter is enabled with the INSTR_COUNT_EN macro.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INSTR_W    = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR)
`ifdef INSTR_COUNT_EN
  ,
  parameter int                CNT_W      = DEF_CNT_W
`endif
) (
  input  logic               CLK,
  input  logic               ResetN,
  input  logic               Start,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic               BranchRel,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic               HaltReq,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [ADDR_W-1:0]  IRAddr,
  output logic               InstrValid,
  output logic               Running,
`ifdef INSTR_COUNT_EN
  output logic [CNT_W-1:0]   InstrCount,
`endif
  output logic               Done
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_addr_q, ir_addr_d;
  logic               valid_q, valid_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               start_ok_s;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  br_target_s;

  assign start_ok_s = Start && ((state_q == IDLE) || (state_q == HALTED));
  assign pc_inc_s   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  // A same-width add wraps modulo 2^ADDR_W, which equals adding the sign-extended offset.
  assign br_target_s = BranchRel ? (ir_addr_q + BranchTarget) : BranchTarget;

  // Next-state, next-PC and instruction register update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ir_addr_d = ir_addr_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start_ok_s) begin
          pc_d    = START_ADDR;
          state_d = FETCH;
        end else begin
          state_d = state_q;
        end
      end
      FETCH: begin
        if (Stall) begin
          state_d = state_q;
        end else begin
          ir_d      = InstrIn;
          ir_addr_d = pc_q;
          pc_d      = pc_inc_s;
          valid_d   = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (Stall) begin
          state_d = state_q;
        end else if (valid_q && HaltReq) begin
          valid_d = 1'b0;
          state_d = HALTED;
        end else if (valid_q && BranchTaken) begin
          pc_d    = br_target_s;
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          ir_d      = InstrIn;
          ir_addr_d = pc_q;
          pc_d      = pc_inc_s;
          valid_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Status flags follow the next state so they line up with the state register.
  always_comb begin
    running_d = (state_d == FETCH) || (state_d == RUN);
    done_d    = (state_d == HALTED);
  end

  // Sequencer state and output registers.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      ir_q      <= {INSTR_W{1'b0}};
      ir_addr_q <= {ADDR_W{1'b0}};
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ir_addr_q <= ir_addr_d;
      valid_q   <= valid_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign Address    = pc_q;
  assign InstrOut   = ir_q;
  assign IRAddr     = ir_addr_q;
  assign InstrValid = valid_q;
  assign Running    = running_q;
  assign Done       = done_q;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_s;

  assign retire_s = (state_q == RUN) && valid_q && !Stall;

  // Retired-instruction counter: cleared on accepted Start, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (retire_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign InstrCount = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: ROM model, abstract sequencer model and directed stimulus.
// Define INSTR_COUNT_EN to also check the retired-instruction counter.
module tb_fetch_sequencer;

  localparam int M_IDLE   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_RUN    = 2;
  localparam int M_HALTED = 3;

  logic       CLK = 1'b0;
  logic       ResetN, Start, Stall, BranchTaken, BranchRel, HaltReq;
  logic [7:0] BranchTarget;
  logic [7:0] Address;
  logic [8:0] InstrIn, InstrOut;
  logic [7:0] IRAddr;
  logic       InstrValid, Running, Done;
  logic [15:0] InstrCount;

  logic [8:0] rom [256];
  assign InstrIn = rom[Address];

  always #5 CLK = ~CLK;

  fetch_sequencer dut (
    .CLK(CLK), .ResetN(ResetN), .Start(Start), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchRel(BranchRel), .BranchTarget(BranchTarget),
    .HaltReq(HaltReq), .Address(Address), .InstrIn(InstrIn), .InstrOut(InstrOut),
    .IRAddr(IRAddr), .InstrValid(InstrValid), .Running(Running),
`ifdef INSTR_COUNT_EN
    .InstrCount(InstrCount),
`endif
    .Done(Done)
  );

`ifndef INSTR_COUNT_EN
  assign InstrCount = 16'd0;
`endif

  int checks = 0;
  int errors = 0;

  // Abstract model: mode, next fetch address, the instruction in IR and where it came from.
  int       m_mode, m_pc, m_ir_addr, m_valid, m_count;
  logic [8:0] m_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_ir = 9'd0; m_ir_addr = 0; m_valid = 0; m_count = 0;
  endtask

  task automatic model_load();
    m_ir = rom[m_pc]; m_ir_addr = m_pc; m_pc = (m_pc + 1) % 256; m_valid = 1;
  endtask

  task automatic model_step();
    int off;
    if (!ResetN) begin
      model_reset();
    end else if (m_mode == M_IDLE || m_mode == M_HALTED) begin
      if (Start) begin m_pc = 0; m_mode = M_FETCH; m_count = 0; end
    end else if (!Stall) begin
      if (m_mode == M_FETCH) begin
        model_load(); m_mode = M_RUN;
      end else begin
        if (m_valid == 1 && m_count < 65535) m_count++;
        if (m_valid == 1 && HaltReq) begin
          m_valid = 0; m_mode = M_HALTED;
        end else if (m_valid == 1 && BranchTaken) begin
          off = (int'(BranchTarget) >= 128) ? int'(BranchTarget) - 256 : int'(BranchTarget);
          m_pc = BranchRel ? (m_ir_addr + off + 256) % 256 : int'(BranchTarget);
          m_valid = 0; m_mode = M_FETCH;
        end else begin
          model_load();
        end
      end
    end
  endtask

  task automatic compare();
    check("address", 32'(Address), 32'(m_pc));
    check("instr_out", 32'(InstrOut), 32'(m_ir));
    check("ir_addr", 32'(IRAddr), 32'(m_ir_addr));
    check("instr_valid", 32'(InstrValid), 32'(m_valid));
    check("running", 32'(Running), 32'((m_mode == M_FETCH) || (m_mode == M_RUN)));
    check("done", 32'(Done), 32'(m_mode == M_HALTED));
`ifdef INSTR_COUNT_EN
    check("instr_count", 32'(InstrCount), 32'(m_count));
`endif
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    compare();
  endtask

  task automatic branch(input logic rel, input logic [7:0] tgt);
    BranchTaken = 1'b1; BranchRel = rel; BranchTarget = tgt;
    cycle();
    BranchTaken = 1'b0; BranchRel = 1'b0;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'((i * 37 + 11) % 512);
    ResetN = 1'b1; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
    BranchRel = 1'b0; BranchTarget = 8'h00; HaltReq = 1'b0;
    model_reset();
    #1 ResetN = 1'b0;
    #1 compare();
    check("lit_reset_addr", 32'(Address), 32'h0);
    check("lit_reset_running", 32'(Running), 32'h0);
    cycle(); cycle();
    #2 ResetN = 1'b1;
    cycle(); cycle();

    // Straight-line fetch.
    Start = 1'b1; cycle(); Start = 1'b0;
    check("lit_fetch_running", 32'(Running), 32'h1);
    check("lit_fetch_valid", 32'(InstrValid), 32'h0);
    cycle();
    check("lit_first_iraddr", 32'(IRAddr), 32'h0);
    check("lit_first_ir", 32'(InstrOut), 32'd11);
    check("lit_first_valid", 32'(InstrValid), 32'h1);
    cycle(); cycle(); cycle();
    check("lit_iraddr3", 32'(IRAddr), 32'h3);

    // Absolute branch to 0x40.
    BranchTaken = 1'b1; BranchTarget = 8'h40; cycle(); BranchTaken = 1'b0;
    check("lit_bubble", 32'(InstrValid), 32'h0);
    cycle();
    check("lit_abs_iraddr", 32'(IRAddr), 32'h40);
    check("lit_abs_addr", 32'(Address), 32'h41);

    // Relative branches, including modulo wrap.
    branch(1'b0, 8'h02);
    check("lit_at2", 32'(IRAddr), 32'h2);
    branch(1'b1, 8'hFE);
    check("lit_rel_back", 32'(IRAddr), 32'h0);
    branch(1'b0, 8'hFF);
    check("lit_at_ff", 32'(IRAddr), 32'hFF);
    check("lit_pc_wrap", 32'(Address), 32'h0);
    branch(1'b1, 8'h01);
    check("lit_rel_wrap", 32'(IRAddr), 32'h0);

    // Stall with branch held, then a stalled bubble.
    BranchTaken = 1'b1; BranchTarget = 8'h20; Stall = 1'b1;
    repeat (3) cycle();
    check("lit_stall_iraddr", 32'(IRAddr), 32'h0);
    check("lit_stall_addr", 32'(Address), 32'h1);
    Stall = 1'b0; cycle();
    check("lit_stall_branch", 32'(Address), 32'h20);
    BranchTaken = 1'b0; Stall = 1'b1; cycle(); Stall = 1'b0; cycle();
    check("lit_after_stall", 32'(IRAddr), 32'h20);

    // Halt, then restart and halt at IRAddr 5.
    HaltReq = 1'b1; cycle(); HaltReq = 1'b0;
    check("lit_halt_done", 32'(Done), 32'h1);
    check("lit_halt_pc", 32'(Address), 32'h21);
    cycle(); Stall = 1'b1; cycle(); Stall = 1'b0;
    Start = 1'b1; cycle(); Start = 1'b0;
    check("lit_restart_addr", 32'(Address), 32'h0);
    cycle(); cycle(); cycle();
    Start = 1'b1; cycle(); Start = 1'b0;
    cycle(); cycle();
    check("lit_iraddr5", 32'(IRAddr), 32'h5);
    HaltReq = 1'b1; cycle(); HaltReq = 1'b0;
    check("lit_halt5_done", 32'(Done), 32'h1);
    check("lit_halt5_running", 32'(Running), 32'h0);
`ifdef INSTR_COUNT_EN
    check("lit_count6", 32'(InstrCount), 32'd6);
`endif
    Start = 1'b1; cycle(); Start = 1'b0;
`ifdef INSTR_COUNT_EN
    check("lit_count_clear", 32'(InstrCount), 32'd0);
`endif

    // Asynchronous reset in the bubble after a branch.
    cycle(); cycle();
    BranchTaken = 1'b1; BranchTarget = 8'h10; cycle(); BranchTaken = 1'b0;
    #1 ResetN = 1'b0; Start = 1'b1;
    model_reset();
    #1 compare();
    check("lit_async_valid", 32'(InstrValid), 32'h0);
    check("lit_async_addr", 32'(Address), 32'h0);
    cycle();
    check("lit_start_in_reset", 32'(Running), 32'h0);
    #2 Start = 1'b0; ResetN = 1'b1;
    cycle();

    // Stall ignored in IDLE, honoured in FETCH.
    Start = 1'b1; Stall = 1'b1; cycle(); Start = 1'b0;
    check("lit_idle_stall", 32'(Running), 32'h1);
    cycle(); Stall = 1'b0; cycle();
    check("lit_final_iraddr", 32'(IRAddr), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
